// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings and
// elaboration-time helpers for the baud divider and counter widths.
package uart_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // Bits needed to hold 0..value-1; never less than 1 so vectors stay legal.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running modulo-DIV counter producing a one-clk tick every DIV clocks;
// clr restarts the period so ticks line up with a detected start edge.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = clog2(DIV);

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == W'(DIV - 1));
    assign tick   = at_end && !clr;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver: synchronises rx, oversamples with 2-of-3 majority voting,
// and emits one-cycle rx_vld / rx_err pulses per frame.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_vld,
    output logic [7:0] rx_data,
    output logic       rx_err
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW   = clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;

    logic          rx_m;
    logic          rx_s;
    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [SW-1:0] s_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          smp_a;
    logic          smp_b;
    logic          tick;
    logic          clr;
    logic          s_wrap;
    logic          maj_tick;
    logic          maj;
    logic          shift_en;
    logic          byte_done;
    logic          frame_err;

    // Synchroniser resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign clr = (state == S_IDLE) && !rx_s;

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    assign s_wrap   = tick && (s_cnt == SW'(OVERSAMPLE - 1));
    assign maj_tick = tick && (s_cnt == SW'(HALF + 1));
    // Third vote is the live sample taken on the deciding tick.
    assign maj      = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults first in every combinational block so no path leaves a value held (no latch).
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!rx_s) next_state = S_START;
            S_START: begin
                if (maj_tick && maj) next_state = S_IDLE;
                else if (s_wrap)     next_state = S_DATA;
            end
            S_DATA:  if (s_wrap && bit_idx == 3'd7) next_state = S_STOP;
            S_STOP:  if (maj_tick) next_state = maj ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state)
            S_DATA: shift_en = maj_tick;
            S_STOP: begin
                byte_done = maj_tick && maj;
                frame_err = maj_tick && !maj;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_cnt <= '0;
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            if (state == S_IDLE || state == S_BREAK) begin
                s_cnt <= '0;
            end else if (s_wrap) begin
                s_cnt <= '0;
            end else if (tick) begin
                s_cnt <= s_cnt + 1'b1;
            end
            if (tick && s_cnt == SW'(HALF - 1)) smp_a <= rx_s;
            if (tick && s_cnt == SW'(HALF))     smp_b <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            rx_data <= 8'h00;
            rx_vld  <= 1'b0;
            rx_err  <= 1'b0;
        end else begin
            if (state != S_DATA) begin
                bit_idx <= 3'd0;
            end else if (s_wrap) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) shreg[bit_idx] <= maj;
            if (byte_done) rx_data <= shreg;
            rx_vld <= byte_done;
            rx_err <= frame_err;
        end
    end

endmodule
